// File: rtl/controller_irq_arbiter.sv
// Eight-channel edge-capturing interrupt controller with a round-robin arbiter
// and an Avalon-MM slave register file.
module controller_irq_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [7:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [7:0] s1, s2, s3;
  logic [7:0] edge_sel, mask, pending;
  logic [7:0] edge_det, elig, w1c_clr, ack_clr, pending_next;
  logic [2:0] grant, ptr, pick, cand;
  logic       found, enable;
  logic       wr, wr_w1c, wr_ack;
  logic       unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  assign wr     = chipselect & ~write_n;
  assign wr_w1c = wr && (address == 3'd3);
  assign wr_ack = wr && (address == 3'd5);

  assign edge_det = (s2 & ~s3 & ~edge_sel) | (~s2 & s3 & edge_sel);
  assign elig     = pending & mask;
  assign w1c_clr  = wr_w1c ? writedata[7:0] : 8'h00;

  // An ACK only retires the granted channel; an ACK while idle does nothing.
  always_comb begin
    ack_clr = 8'h00;
    if (state == GRANT && wr_ack)
      ack_clr[grant] = 1'b1;
  end

  // New edges override any clear in the same cycle so no event is lost.
  assign pending_next = (pending & ~(w1c_clr | ack_clr)) | edge_det;

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && elig[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 8'h00;
      s2       <= 8'h00;
      s3       <= 8'h00;
      edge_sel <= 8'h00;
      mask     <= 8'h00;
      pending  <= 8'h00;
      enable   <= 1'b0;
    end else begin
      s1      <= in_port;
      s2      <= s1;
      s3      <= s2;
      pending <= pending_next;
      if (wr && address == 3'd1) edge_sel <= writedata[7:0];
      if (wr && address == 3'd2) mask     <= writedata[7:0];
      if (wr && address == 3'd6) enable   <= writedata[0];
    end
  end

  // Grant is held until acknowledged or until the channel stops being eligible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= 3'd0;
      ptr   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (wr_ack) begin
            ptr   <= grant + 3'd1;
            state <= IDLE;
          end else if (!elig[grant]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0;
    end else begin
      case (address)
        3'd0:    readdata <= {24'h0, s2};
        3'd1:    readdata <= {24'h0, edge_sel};
        3'd2:    readdata <= {24'h0, mask};
        3'd3:    readdata <= {24'h0, pending};
        3'd4:    readdata <= {(state == GRANT), 28'h0, grant};
        3'd6:    readdata <= {31'h0, enable};
        default: readdata <= 32'h0;
      endcase
    end
  end

  assign irq = (state == GRANT) & enable;

endmodule

// File: tb/tb_controller_irq_arbiter.sv
// Directed-vector bench for controller_irq_arbiter with hand-computed expectations.
module tb_controller_irq_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checkCount;
  int errorCount;

  controller_irq_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle bus write; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    address = addr;
    tick(1);
    checkOutput(tag, readdata, expected);
  endtask

  task automatic pulse(input logic [7:0] bits);
    in_port = bits;
    tick(1);
    in_port = 8'h00;
  endtask

  task automatic doReset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    in_port    = 8'h00;
    #1;
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_rdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;

    // Reset values of every register.
    doReset();
    readCheck("rst_level", 3'd0, 32'h0);
    readCheck("rst_edgesel", 3'd1, 32'h0);
    readCheck("rst_mask", 3'd2, 32'h0);
    readCheck("rst_pending", 3'd3, 32'h0);
    readCheck("rst_vector", 3'd4, 32'h0);
    readCheck("rst_ctrl", 3'd6, 32'h0);

    // Single rising pulse on channel 3: latency to pending and to irq.
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd6, 32'h1);
    in_port = 8'h08;
    address = 3'd3;
    tick(1);
    in_port = 8'h00;
    checkOutput("lat_irq_k", {31'h0, irq}, 32'h0);
    tick(1);
    tick(1);
    checkOutput("lat_pend_k2", readdata, 32'h0);
    checkOutput("lat_irq_k2", {31'h0, irq}, 32'h0);
    tick(1);
    checkOutput("lat_pend_k3", readdata, 32'h08);
    checkOutput("lat_irq_k3", {31'h0, irq}, 32'h1);
    readCheck("lat_vector", 3'd4, 32'h80000003);
    applyStimulus(3'd5, 32'h0);
    checkOutput("ack_irq", {31'h0, irq}, 32'h0);
    readCheck("ack_pending", 3'd3, 32'h0);

    // Round-robin order 1,5,6 then a late channel 1 event waits behind 6.
    doReset();
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd6, 32'h1);
    pulse(8'h62);
    tick(4);
    readCheck("rr_g1", 3'd4, 32'h80000001);
    applyStimulus(3'd5, 32'h0);
    tick(2);
    readCheck("rr_g5", 3'd4, 32'h80000005);
    pulse(8'h02);
    tick(4);
    readCheck("rr_hold5", 3'd4, 32'h80000005);
    readCheck("rr_pend", 3'd3, 32'h62);
    applyStimulus(3'd5, 32'h0);
    tick(2);
    readCheck("rr_g6", 3'd4, 32'h80000006);
    applyStimulus(3'd5, 32'h0);
    tick(2);
    readCheck("rr_g1b", 3'd4, 32'h80000001);
    applyStimulus(3'd5, 32'h0);
    tick(2);
    readCheck("rr_idle_vec", 3'd4, 32'h00000001);
    readCheck("rr_pend_empty", 3'd3, 32'h0);

    // Falling-edge selection on channel 0.
    doReset();
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd6, 32'h1);
    applyStimulus(3'd1, 32'h1);
    readCheck("es_readback", 3'd1, 32'h1);
    in_port = 8'h01;
    tick(4);
    readCheck("es_level", 3'd0, 32'h1);
    readCheck("es_rise_ignored", 3'd3, 32'h0);
    in_port = 8'h00;
    tick(4);
    readCheck("es_fall_set", 3'd3, 32'h1);
    checkOutput("es_irq", {31'h0, irq}, 32'h1);
    applyStimulus(3'd5, 32'h0);
    readCheck("es_ack_clr", 3'd3, 32'h0);

    // Masking out the granted channel drops to IDLE without moving the pointer.
    doReset();
    applyStimulus(3'd2, 32'hFF);
    applyStimulus(3'd6, 32'h1);
    pulse(8'h04);
    tick(4);
    checkOutput("mk_irq_on", {31'h0, irq}, 32'h1);
    readCheck("mk_vec2", 3'd4, 32'h80000002);
    applyStimulus(3'd2, 32'h00);
    tick(1);
    checkOutput("mk_irq_off", {31'h0, irq}, 32'h0);
    readCheck("mk_vec_idle", 3'd4, 32'h00000002);
    pulse(8'h20);
    tick(3);
    readCheck("mk_pending", 3'd3, 32'h24);
    applyStimulus(3'd2, 32'hFF);
    tick(1);
    checkOutput("mk_irq_regrant", {31'h0, irq}, 32'h1);
    readCheck("mk_regrant2", 3'd4, 32'h80000002);
    applyStimulus(3'd5, 32'h0);
    tick(2);
    readCheck("mk_then5", 3'd4, 32'h80000005);

    // W1C colliding with a new edge, ACK while idle, and the unused address.
    doReset();
    pulse(8'h10);
    tick(3);
    readCheck("w1c_pend_set", 3'd3, 32'h10);
    in_port = 8'h10;
    tick(1);
    in_port = 8'h00;
    tick(1);
    applyStimulus(3'd3, 32'h10);
    readCheck("w1c_set_wins", 3'd3, 32'h10);
    applyStimulus(3'd5, 32'h0);
    readCheck("idle_ack_noop", 3'd3, 32'h10);
    readCheck("idle_vec", 3'd4, 32'h0);
    applyStimulus(3'd3, 32'h10);
    readCheck("w1c_clear", 3'd3, 32'h0);
    applyStimulus(3'd7, 32'hFFFFFFFF);
    readCheck("addr7_zero", 3'd7, 32'h0);

    // Enable only gates irq; arbitration proceeds regardless.
    doReset();
    applyStimulus(3'd2, 32'hFF);
    pulse(8'h80);
    tick(4);
    checkOutput("en0_irq", {31'h0, irq}, 32'h0);
    readCheck("en0_vec", 3'd4, 32'h80000007);
    applyStimulus(3'd6, 32'h1);
    checkOutput("en1_irq", {31'h0, irq}, 32'h1);
    readCheck("en1_ctrl", 3'd6, 32'h1);

    // Asynchronous reset mid-GRANT, with channel 0 held high through reset.
    in_port = 8'h01;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_irq", {31'h0, irq}, 32'h0);
    checkOutput("arst_rdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(4);
    readCheck("arst_pending", 3'd3, 32'h01);
    readCheck("arst_vec", 3'd4, 32'h0);
    applyStimulus(3'd3, 32'h01);
    tick(4);
    readCheck("arst_one_edge", 3'd3, 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
